memory_access_stage: RTL
========================

Name: memory_access_stage

Overview:
- Pipeline stage that consumes the execute-stage result bundle (alu_data, memory_data, control, compflg) and performs the data-memory access.
- Generates byte enables and lane-replicated store data. Aligns and sign/zero-extends load data.
- Drives a req/ack data-memory bus with an abort timeout.
- Registers the result bundle toward write-back and stalls upstream while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ without dmem_ack before the access is aborted with bus_error; legal range 2..255.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  reset; one clock, asynchronous, active-low
- valid_in  input  1  upstream bundle valid
- alu_data_in  input  32  effective address (memory ops) or ALU result
- memory_data_in  input  32  store data (rs2)
- control_in  input  control_type  uses mem_read, mem_write, funct3
- compflg_in  input  1  compressed-instruction flag
- stall_out  output  1  upstream must hold inputs stable
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word address: alu_data_in with [1:0] = 0
- dmem_wdata  output  32  store data, lane-replicated
- dmem_be  output  4  byte enables
- dmem_ack  input  1  bus completion; rdata valid the same cycle
- dmem_rdata  input  32  read word
- valid_out  output  1  result bundle valid
- control_out  output  control_type  registered control
- alu_data_out  output  32  registered alu_data_in
- mem_data_out  output  32  extended load data, else 0
- compflg_out  output  1  registered compflg_in
- misaligned_flag  output  1  access not naturally aligned
- bus_error  output  1  access timed out

Behaviour:
- Reset: all outputs 0; FSM = IDLE; timeout counter = 0.
  - Asynchronous assertion mid-access drops dmem_req immediately (dmem_req is decoded from state).
  - A later ack for the aborted access is ignored.
- FSM states: IDLE, REQ.
- IDLE, valid_in & !(mem_read | mem_write): 1-cycle registered pass-through.
  - valid_out = 1, mem_data_out = 0, flags = 0.
- IDLE, valid_in, memory op, misaligned: no bus request.
  - Misaligned means LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - Next cycle: valid_out = 1, misaligned_flag = 1, mem_data_out = 0; no write performed.
- IDLE, valid_in, aligned memory op: go to REQ; counter = 0.
- REQ:
  - dmem_req = 1; dmem_we = mem_write; addr/wdata/be are stable and derived from the held inputs.
  - stall_out = 1 while in REQ and dmem_ack = 0.
  - dmem_ack = 1: register the result, return to IDLE, valid_out = 1 next cycle. A zero-wait ack in the first REQ cycle gives 2-cycle total latency.
  - Counter reaching TIMEOUT_CYCLES-1 with no ack: return to IDLE; next cycle valid_out = 1, bus_error = 1, mem_data_out = 0.
- valid_out is a 1-cycle pulse per completed instruction. It is 0 during stall cycles (bubble).
- A new instruction is accepted in IDLE only. The cycle after completion, a held valid_in is the next instruction; upstream advances once stall_out drops.
- Store byte enables, with lane = addr[1:0]:
  - SB: be = 1<<lane, wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 or 1100, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Loads: be = 1111 for all sizes. Extract the selected byte/halfword from dmem_rdata at the lane.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Unsupported funct3 on a memory op is treated as misaligned (flag set, no access).
- mem_read and mem_write both set: treated as a read.

Decomposition:
- common package: mem_state_t enum {IDLE, REQ}; funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010.
- Sub-module load_data_aligner (combinational): inputs rdata, lane, funct3; output extended 32-bit data.

Test Plan:
- ADD bundle, alu_data_in=0x0000_1234, no mem op -> next cycle valid_out=1, alu_data_out=0x1234, dmem_req never asserted, stall_out=0.
- SB addr=0x103, rs2=0xAABB_CCDD, ack after 3 cycles -> dmem_addr=0x100, be=1000, wdata=0xDDDD_DDDD, stall_out high 3 cycles, then valid_out=1.
- LB addr=0x202, rdata=0x0080_0000, zero-wait ack -> mem_data_out=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- LW addr=0x206 -> no dmem_req, next cycle valid_out=1, misaligned_flag=1, mem_data_out=0.
- LW addr=0x300, ack never arrives, TIMEOUT_CYCLES=16 -> dmem_req high exactly 16 cycles, then valid_out=1, bus_error=1; ack 2 cycles later produces no extra valid_out.
- reset_n low in 2nd REQ cycle of an SW -> dmem_req, stall_out, valid_out = 0 immediately; after release FSM in IDLE, a fresh LH addr=0x10, rdata=0x0000_8001 returns 0xFFFF_8001.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the data-memory access stage.
// Holds the bus FSM state, the control bundle layout and the load/store size decode.
package memory_access_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } control_type;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unsupported sizes report as misaligned so they never reach the bus.
  function automatic logic is_misaligned(input logic       is_read,
                                         input logic [2:0] funct3,
                                         input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    if (is_read) begin
      case (funct3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = lane[0];
        F3_LW:         bad = |lane;
        default:       bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = lane[0];
        F3_SW:   bad = |lane;
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/memory_access_stage_load_data_aligner.sv
// Picks the addressed byte/halfword out of a read word and extends it to 32 bits.
// Purely combinational; the caller qualifies the result with the access that produced it.
module load_data_aligner
  import memory_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane_byte[lane];
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: runs one req/ack data-memory access per load/store with an abort
// timeout, and registers the execute bundle toward write-back.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] memory_data_in,
  input  control_type control_in,
  input  logic        compflg_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output control_type control_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] mem_data_out,
  output logic        compflg_out,
  output logic        misaligned_flag,
  output logic        bus_error
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic [1:0]  lane;
  logic        is_read, is_write, is_mem_op, misaligned;
  logic        accept_pass, accept_misal, accept_bus;
  logic        ack_hit, timeout_hit, complete;
  logic [3:0]  sb_be;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_data;

  assign lane      = alu_data_in[1:0];
  assign is_read   = control_in.mem_read;
  assign is_write  = control_in.mem_write & ~control_in.mem_read;
  assign is_mem_op = control_in.mem_read | control_in.mem_write;
  assign misaligned = is_mem_op & is_misaligned(is_read, control_in.funct3, lane);

  assign accept_pass  = (state_reg == IDLE) & valid_in & ~is_mem_op;
  assign accept_misal = (state_reg == IDLE) & valid_in & misaligned;
  assign accept_bus   = (state_reg == IDLE) & valid_in & is_mem_op & ~misaligned;
  assign ack_hit      = (state_reg == REQ) & dmem_ack;
  assign timeout_hit  = (state_reg == REQ) & ~dmem_ack & (cnt_reg == CNT_LAST);
  assign complete     = accept_pass | accept_misal | ack_hit | timeout_hit;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sb_be
      assign sb_be[gi] = (lane == 2'(gi));
    end
  endgenerate

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = memory_data_in;
    if (is_write) begin
      case (control_in.funct3)
        F3_SB: begin
          be_calc    = sb_be;
          wdata_calc = {4{memory_data_in[7:0]}};
        end
        F3_SH: begin
          be_calc    = lane[1] ? 4'b1100 : 4'b0011;
          wdata_calc = {2{memory_data_in[15:0]}};
        end
        default: begin
          be_calc    = 4'b1111;
          wdata_calc = memory_data_in;
        end
      endcase
    end
  end

  load_data_aligner u_aligner (
    .rdata  (dmem_rdata),
    .lane   (lane),
    .funct3 (control_in.funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept_bus) begin
          state_next = REQ;
          cnt_next   = 8'd0;
        end
      end
      REQ: begin
        if (ack_hit || timeout_hit) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Stall also covers the accept cycle so the instruction stays on the inputs
  // for the whole access; it drops in the completing cycle (ack or abort).
  always_comb begin
    dmem_req   = (state_reg == REQ);
    dmem_we    = dmem_req & is_write;
    dmem_addr  = dmem_req ? {alu_data_in[31:2], 2'b00} : 32'h0;
    dmem_be    = dmem_req ? be_calc : 4'b0000;
    dmem_wdata = dmem_req ? wdata_calc : 32'h0;
    stall_out  = reset_n & (accept_bus | ((state_reg == REQ) & ~ack_hit & ~timeout_hit));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out       <= 1'b0;
      control_out     <= '0;
      alu_data_out    <= 32'h0;
      mem_data_out    <= 32'h0;
      compflg_out     <= 1'b0;
      misaligned_flag <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      valid_out       <= complete;
      misaligned_flag <= accept_misal;
      bus_error       <= timeout_hit;
      if (complete) begin
        control_out  <= control_in;
        alu_data_out <= alu_data_in;
        compflg_out  <= compflg_in;
        mem_data_out <= (ack_hit && is_read) ? load_data : 32'h0;
      end
    end
  end

endmodule
